// File: rtl/shift_operand_decoder.sv
// shift_operand_decoder: decodes ARM operand2 into barrel-shifter controls and the architectural carry-out.
// SHIFT_DECODE_RSREG_EN enables register-shifted-register decode with the Rs read handshake.
module shift_operand_decoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_i,
   input  logic [11:0] in_op2,
   input  logic [31:0] in_rm_data,
   input  logic        in_carry,
   output logic        rs_req,
   output logic [3:0]  rs_addr,
   input  logic        rs_valid,
   input  logic [31:0] rs_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] sh_a,
   output logic [2:0]  sh_opcode,
   output logic [4:0]  sh_shift,
   output logic        sh_carry_in,
   output logic        carry_out,
   output logic        illegal
);
   localparam logic [2:0] LSL = 3'd0, LSR = 3'd1, ASR = 3'd2, ROR = 3'd3, RRX = 3'd4;

`ifdef SHIFT_DECODE_RSREG_EN
   typedef enum logic [1:0] {IDLE, RS_WAIT, OUT} state_t;
`else
   typedef enum logic [1:0] {IDLE, OUT} state_t;
`endif

   typedef struct packed {
      logic [31:0] a;
      logic [2:0]  op;
      logic [4:0]  sh;
      logic        co;
      logic        ill;
   } ctl_t;

   // The shifter rotates left, so right rotations are expressed as 32 - amount.
   function automatic ctl_t dec(input logic imm, input logic [11:0] op2, input logic [31:0] rm,
                                input logic cin, input logic [7:0] rs);
      ctl_t c;
      logic [4:0] n, m;
      logic [63:0] rv;
      n = op2[11:7];
      m = rs[4:0];
      rv = {2{{24'd0, op2[7:0]}}} >> {op2[11:8], 1'b0};
      c = '{a: rm, op: LSL, sh: 5'd0, co: cin, ill: 1'b0};
      if (imm)
         c = '{a: {24'd0, op2[7:0]}, op: ROR, sh: 5'd0 - {op2[11:8], 1'b0},
               co: (op2[11:8] == 4'd0) ? cin : rv[31], ill: 1'b0};
      else if (!op2[4])
         case (op2[6:5])
            2'd0: begin
               c.sh = n;
               c.co = (n == 5'd0) ? cin : rm[5'd0 - n];
            end
            2'd1: begin
               c.op = LSR;
               c.sh = n;
               c.co = (n == 5'd0) ? rm[31] : rm[n - 5'd1];
            end
            2'd2:
               if (n == 5'd0) begin
                  c.a  = {32{rm[31]}};
                  c.co = rm[31];
               end else begin
                  c.op = ASR;
                  c.sh = n;
                  c.co = rm[n - 5'd1];
               end
            default:
               if (n == 5'd0) begin
                  c.op = RRX;
                  c.co = rm[0];
               end else begin
                  c.op = ROR;
                  c.sh = 5'd0 - n;
                  c.co = rm[n - 5'd1];
               end
         endcase
`ifdef SHIFT_DECODE_RSREG_EN
      else if (!op2[7]) begin
         if (rs != 8'd0)
            case (op2[6:5])
               2'd0:
                  if (rs < 8'd32) begin
                     c.sh = m;
                     c.co = rm[5'd0 - m];
                  end else begin
                     c.a  = 32'd0;
                     c.co = (rs == 8'd32) & rm[0];
                  end
               2'd1:
                  if (rs < 8'd32) begin
                     c.op = LSR;
                     c.sh = m;
                     c.co = rm[m - 5'd1];
                  end else if (rs == 8'd32) begin
                     c.op = LSR;
                     c.co = rm[31];
                  end else begin
                     c.a  = 32'd0;
                     c.co = 1'b0;
                  end
               2'd2:
                  if (rs < 8'd32) begin
                     c.op = ASR;
                     c.sh = m;
                     c.co = rm[m - 5'd1];
                  end else begin
                     c.a  = {32{rm[31]}};
                     c.co = rm[31];
                  end
               default:
                  if (m == 5'd0)
                     c.co = rm[31];
                  else begin
                     c.op = ROR;
                     c.sh = 5'd0 - m;
                     c.co = rm[m - 5'd1];
                  end
            endcase
      end
`endif
      else
         c.ill = 1'b1;
      return c;
   endfunction

   state_t state_q, state_d;
   ctl_t   ctl_q, ctl_d, c;
   logic   out_valid_q, out_valid_d;
   logic   cin_q, cin_d;

`ifdef SHIFT_DECODE_RSREG_EN
   logic        rs_req_q, rs_req_d;
   logic [3:0]  rs_addr_q, rs_addr_d;
   logic [11:0] op2_q, op2_d;
   logic [31:0] rm_q, rm_d;
   logic        rs_form;

   assign rs_form = !in_i && in_op2[4] && !in_op2[7];
   assign rs_req  = rs_req_q;
   assign rs_addr = rs_addr_q;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rs_req_q  <= 1'b0;
         rs_addr_q <= 4'd0;
         op2_q     <= 12'd0;
         rm_q      <= 32'd0;
      end else begin
         rs_req_q  <= rs_req_d;
         rs_addr_q <= rs_addr_d;
         op2_q     <= op2_d;
         rm_q      <= rm_d;
      end
`else
   assign rs_req  = 1'b0;
   assign rs_addr = 4'd0;
`endif

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q     <= IDLE;
         ctl_q       <= '0;
         out_valid_q <= 1'b0;
         cin_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ctl_q       <= ctl_d;
         out_valid_q <= out_valid_d;
         cin_q       <= cin_d;
      end

   always_comb begin
      state_d     = state_q;
      ctl_d       = ctl_q;
      out_valid_d = out_valid_q;
      cin_d       = cin_q;
`ifdef SHIFT_DECODE_RSREG_EN
      rs_req_d  = rs_req_q;
      rs_addr_d = rs_addr_q;
      op2_d     = op2_q;
      rm_d      = rm_q;
      c = (state_q == RS_WAIT) ? dec(1'b0, op2_q, rm_q, cin_q, rs_data[7:0])
                               : dec(in_i, in_op2, in_rm_data, in_carry, 8'd0);
`else
      c = dec(in_i, in_op2, in_rm_data, in_carry, 8'd0);
`endif
      case (state_q)
         IDLE:
            if (in_valid) begin
               cin_d = in_carry;
`ifdef SHIFT_DECODE_RSREG_EN
               if (rs_form) begin
                  state_d   = RS_WAIT;
                  rs_req_d  = 1'b1;
                  rs_addr_d = in_op2[11:8];
                  op2_d     = in_op2;
                  rm_d      = in_rm_data;
               end else
`endif
               begin
                  state_d     = OUT;
                  out_valid_d = 1'b1;
                  ctl_d       = c;
               end
            end
`ifdef SHIFT_DECODE_RSREG_EN
         RS_WAIT:
            if (rs_valid) begin
               state_d     = OUT;
               rs_req_d    = 1'b0;
               out_valid_d = 1'b1;
               ctl_d       = c;
            end
`endif
         OUT:
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = out_valid_q;
   assign sh_a        = ctl_q.a;
   assign sh_opcode   = ctl_q.op;
   assign sh_shift    = ctl_q.sh;
   assign sh_carry_in = cin_q;
   assign carry_out   = ctl_q.co;
   assign illegal     = ctl_q.ill;
endmodule

// File: tb/tb_shift_operand_decoder.sv
// tb_shift_operand_decoder: randomized and directed checks of shift_operand_decoder against an
// architectural ARM shifter model; honours SHIFT_DECODE_RSREG_EN like the design.
module tb_shift_operand_decoder;
   logic        clk = 1'b0, reset = 1'b1;
   logic        in_valid = 1'b0, in_ready, in_i = 1'b0, in_carry = 1'b0;
   logic [11:0] in_op2 = '0;
   logic [31:0] in_rm_data = '0, rs_data = '0;
   logic        rs_req, rs_valid = 1'b0, out_valid, out_ready = 1'b0;
   logic [3:0]  rs_addr;
   logic [31:0] sh_a;
   logic [2:0]  sh_opcode;
   logic [4:0]  sh_shift;
   logic        sh_carry_in, carry_out, illegal;
   int          n_vec = 0, n_err = 0;

`ifdef SHIFT_DECODE_RSREG_EN
   localparam bit RS_EN = 1'b1;
`else
   localparam bit RS_EN = 1'b0;
`endif

   shift_operand_decoder dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i),
      .in_op2(in_op2), .in_rm_data(in_rm_data), .in_carry(in_carry), .rs_req(rs_req),
      .rs_addr(rs_addr), .rs_valid(rs_valid), .rs_data(rs_data), .out_valid(out_valid),
      .out_ready(out_ready), .sh_a(sh_a), .sh_opcode(sh_opcode), .sh_shift(sh_shift),
      .sh_carry_in(sh_carry_in), .carry_out(carry_out), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Architectural shift by amt: {carry, result}
   function automatic logic [32:0] shift_arch(input logic [1:0] ty, input logic [31:0] rm,
                                              input logic cin, input int amt);
      logic [63:0] r;
      int m;
      if (amt == 0) return {cin, rm};
      case (ty)
         2'd0: begin r = {32'd0, rm} << amt; return {r[32], r[31:0]}; end
         2'd1: begin r = {rm, 32'd0} >> amt; return {r[31], r[63:32]}; end
         2'd2: begin r = $signed({rm, 32'd0}) >>> amt; return {r[31], r[63:32]}; end
         default: begin
            m = amt % 32;
            if (m == 0) return {rm[31], rm};
            r = {rm, rm} >> m;
            return {r[31], r[31:0]};
         end
      endcase
   endfunction

   // Full operand2 semantics: {illegal, carry, value}
   function automatic logic [33:0] arch(input logic i, input logic [11:0] op2, input logic [31:0] rm,
                                        input logic cin, input logic [7:0] rs);
      logic [31:0] v;
      int amt;
      if (i) begin
         v = {24'd0, op2[7:0]};
         for (int k = 0; k < 2 * op2[11:8]; k++) v = {v[0], v[31:1]};
         return {1'b0, (op2[11:8] == 4'd0) ? cin : v[31], v};
      end
      if (op2[4] && (op2[7] || !RS_EN)) return {1'b1, cin, rm};
      if (op2[4]) amt = rs;
      else begin
         amt = op2[11:7];
         if (amt == 0 && op2[6:5] == 2'd3) return {1'b0, rm[0], cin, rm[31:1]};
         if (amt == 0 && op2[6:5] != 2'd0) amt = 32;
      end
      return {1'b0, shift_arch(op2[6:5], rm, cin, amt)};
   endfunction

   // Downstream barrel shifter as documented (ROR rotates left, LSR/ASR #0 give 0)
   function automatic logic [31:0] shifter(input logic [31:0] a, input logic [2:0] op,
                                           input logic [4:0] s, input logic c);
      case (op)
         3'd0: return a << s;
         3'd1: return (s == 5'd0) ? 32'd0 : a >> s;
         3'd2: return (s == 5'd0) ? 32'd0 : 32'($signed(a) >>> s);
         3'd3: return (a << s) | (a >> (6'd32 - {1'b0, s}));
         3'd4: return {c, a[31:1]};
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic run_op(input logic i, input logic [11:0] op2, input logic [31:0] rm,
                         input logic c, input logic [7:0] rs, input int dly, output int lat);
      bit rsf;
      rsf = RS_EN && !i && op2[4] && !op2[7];
      in_valid = 1'b1; in_i = i; in_op2 = op2; in_rm_data = rm; in_carry = c;
      @(posedge clk); #1;
      in_valid = 1'b0; in_op2 = 12'($urandom); in_rm_data = $urandom; in_carry = 1'($urandom);
      if (rsf) begin
         for (int k = 0; k < dly; k++) begin
            n_vec++;
            if (rs_req !== 1'b1 || rs_addr !== op2[11:8]) begin
               n_err++;
               $display("FAIL rs_hold: rs_req=%b rs_addr=%h, required 1/%h", rs_req, rs_addr, op2[11:8]);
            end
            @(posedge clk); #1;
         end
         rs_valid = 1'b1; rs_data = {24'($urandom), rs};
         @(posedge clk); #1;
         rs_valid = 1'b0; rs_data = $urandom;
      end
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) begin
         n_vec++; n_err++;
         $display("FAIL out_timeout: out_valid=%b after %0d cycles, required 1", out_valid, lat);
      end
   endtask

   task automatic finish_op();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      #1;
      n_vec++;
      if ({rs_req, rs_addr, out_valid, sh_a, sh_opcode, sh_shift, sh_carry_in, carry_out, illegal, in_ready}
          !== {1'b0, 4'd0, 1'b0, 32'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL reset_state: req=%b addr=%h ov=%b a=%h op=%0d sh=%0d ci=%b co=%b ill=%b rdy=%b, required all 0 rdy 1",
                  rs_req, rs_addr, out_valid, sh_a, sh_opcode, sh_shift, sh_carry_in, carry_out, illegal, in_ready);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_directed_imm();
      int lat;
      run_op(1'b1, 12'h4FF, 32'h1234_5678, 1'b0, 8'd0, 0, lat);
      n_vec++;
      if ({sh_a, sh_opcode, sh_shift, carry_out, lat} !== {32'hFF, 3'd3, 5'd24, 1'b1, 32'd0}) begin
         n_err++;
         $display("FAIL rot_imm: a=%h op=%0d sh=%0d co=%b lat=%0d, required ff/3/24/1/0",
                  sh_a, sh_opcode, sh_shift, carry_out, lat);
      end
      finish_op();
      run_op(1'b0, 12'h040, 32'h8000_0001, 1'b0, 8'd0, 0, lat);
      n_vec++;
      if ({sh_a, sh_opcode, sh_shift, carry_out} !== {32'hFFFF_FFFF, 3'd0, 5'd0, 1'b1}) begin
         n_err++;
         $display("FAIL asr0: a=%h op=%0d sh=%0d co=%b, required ffffffff/0/0/1", sh_a, sh_opcode, sh_shift, carry_out);
      end
      finish_op();
      run_op(1'b0, 12'h060, 32'h0000_0003, 1'b1, 8'd0, 0, lat);
      n_vec++;
      if ({sh_opcode, sh_carry_in, carry_out} !== {3'd4, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL rrx: op=%0d ci=%b co=%b, required 4/1/1", sh_opcode, sh_carry_in, carry_out);
      end
      finish_op();
   endtask

   task automatic test_illegal();
      int lat;
      run_op(1'b0, 12'h090, 32'hCAFE_0001, 1'b1, 8'd0, 0, lat);
      n_vec++;
      if ({illegal, sh_a, sh_opcode, sh_shift, carry_out, lat} !== {1'b1, 32'hCAFE_0001, 3'd0, 5'd0, 1'b1, 32'd0}) begin
         n_err++;
         $display("FAIL mul_space: ill=%b a=%h op=%0d sh=%0d co=%b lat=%0d, required 1/cafe0001/0/0/1/0",
                  illegal, sh_a, sh_opcode, sh_shift, carry_out, lat);
      end
      finish_op();
`ifndef SHIFT_DECODE_RSREG_EN
      run_op(1'b0, 12'h010, 32'h0000_00A5, 1'b0, 8'd0, 0, lat);
      n_vec++;
      if ({illegal, sh_a, sh_opcode, sh_shift, carry_out, lat, rs_req} !== {1'b1, 32'hA5, 3'd0, 5'd0, 1'b0, 32'd0, 1'b0}) begin
         n_err++;
         $display("FAIL no_rsreg: ill=%b a=%h op=%0d sh=%0d co=%b lat=%0d req=%b, required 1/a5/0/0/0/0/0",
                  illegal, sh_a, sh_opcode, sh_shift, carry_out, lat, rs_req);
      end
      finish_op();
`endif
   endtask

`ifdef SHIFT_DECODE_RSREG_EN
   task automatic test_reg_shift();
      int lat;
      run_op(1'b0, 12'h230, 32'h8000_0000, 1'b0, 8'h20, 3, lat);
      n_vec++;
      if ({sh_opcode, sh_shift, carry_out, rs_req} !== {3'd1, 5'd0, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL lsr32: op=%0d sh=%0d co=%b req=%b, required 1/0/1/0", sh_opcode, sh_shift, carry_out, rs_req);
      end
      finish_op();
      run_op(1'b0, 12'h230, 32'h8000_0000, 1'b0, 8'h21, 1, lat);
      n_vec++;
      if ({sh_a, carry_out} !== {32'd0, 1'b0}) begin
         n_err++;
         $display("FAIL lsr33: a=%h co=%b, required 0/0", sh_a, carry_out);
      end
      finish_op();
      run_op(1'b0, 12'h270, 32'h8000_0000, 1'b0, 8'h40, 0, lat);
      n_vec++;
      if ({sh_a, sh_opcode, sh_shift, carry_out} !== {32'h8000_0000, 3'd0, 5'd0, 1'b1}) begin
         n_err++;
         $display("FAIL ror64: a=%h op=%0d sh=%0d co=%b, required 80000000/0/0/1", sh_a, sh_opcode, sh_shift, carry_out);
      end
      finish_op();
      run_op(1'b0, 12'h270, 32'h0000_000F, 1'b0, 8'h04, 2, lat);
      n_vec++;
      if ({sh_opcode, sh_shift, carry_out} !== {3'd3, 5'd28, 1'b1}) begin
         n_err++;
         $display("FAIL ror4: op=%0d sh=%0d co=%b, required 3/28/1", sh_opcode, sh_shift, carry_out);
      end
      finish_op();
   endtask
`endif

   task automatic test_stall();
      int lat;
      logic [43:0] snap;
      run_op(1'b1, 12'($urandom), 32'd0, 1'($urandom), 8'd0, 0, lat);
      snap = {out_valid, sh_a, sh_opcode, sh_shift, sh_carry_in, carry_out, illegal};
      in_valid = 1'b1; in_i = 1'b0; in_op2 = 12'h040; in_rm_data = 32'h8000_0000;
      for (int k = 0; k < 5; k++) begin
         rs_valid = 1'(k & 1); rs_data = $urandom;
         @(posedge clk); #1;
         n_vec++;
         if ({out_valid, sh_a, sh_opcode, sh_shift, sh_carry_in, carry_out, illegal, in_ready} !== {snap, 1'b0}) begin
            n_err++;
            $display("FAIL stall_hold: %h rdy=%b, required %h rdy=0",
                     {out_valid, sh_a, sh_opcode, sh_shift, sh_carry_in, carry_out, illegal}, in_ready, snap);
         end
      end
      in_valid = 1'b0; rs_valid = 1'b0;
      finish_op();
   endtask

   task automatic test_reset_abort();
      int lat;
`ifdef SHIFT_DECODE_RSREG_EN
      in_valid = 1'b1; in_i = 1'b0; in_op2 = 12'h230;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      n_vec++;
      if ({rs_req, out_valid, in_ready} !== 3'b001) begin
         n_err++;
         $display("FAIL abort_rswait: req=%b ov=%b rdy=%b, required 0/0/1", rs_req, out_valid, in_ready);
      end
      @(posedge clk); #1;
      reset = 1'b0;
`endif
      run_op(1'b1, 12'h0FF, 32'd0, 1'b0, 8'd0, 0, lat);
      #2 reset = 1'b1;
      #1;
      n_vec++;
      if ({out_valid, in_ready, sh_a} !== {1'b0, 1'b1, 32'd0}) begin
         n_err++;
         $display("FAIL abort_out: ov=%b rdy=%b a=%h, required 0/1/0", out_valid, in_ready, sh_a);
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_random();
      int lat;
      logic i, c;
      logic [11:0] op2;
      logic [31:0] rm, got;
      logic [7:0] rs;
      logic [33:0] exp;
      for (int t = 0; t < 300; t++) begin
         i = 1'($urandom);
         op2 = 12'($urandom);
         if ($urandom_range(3) != 0 && op2[4]) op2[7] = 1'b0;
         case ($urandom_range(7))
            0: rm = 32'h8000_0000;
            1: rm = 32'h0000_0001;
            default: rm = $urandom;
         endcase
         c = 1'($urandom);
         case ($urandom_range(7))
            0: rs = 8'd0;
            1: rs = 8'd32;
            2: rs = 8'd33;
            3: rs = 8'd31;
            4: rs = 8'd64;
            default: rs = 8'($urandom);
         endcase
         n_vec++;
         if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL idle_ready: in_ready=%b, required 1", in_ready);
         end
         run_op(i, op2, rm, c, rs, $urandom_range(3), lat);
         exp = arch(i, op2, rm, c, rs);
         got = shifter(sh_a, sh_opcode, sh_shift, sh_carry_in);
         n_vec++;
         if ({illegal, carry_out, got, sh_carry_in} !== {exp, c}) begin
            n_err++;
            $display("FAIL random i=%b op2=%h rm=%h c=%b rs=%h: ill=%b co=%b val=%h ci=%b, required %b/%b/%h/%b",
                     i, op2, rm, c, rs, illegal, carry_out, got, sh_carry_in, exp[33], exp[32], exp[31:0], c);
         end
         finish_op();
      end
   endtask

   initial begin
      test_reset();
      test_directed_imm();
      test_illegal();
`ifdef SHIFT_DECODE_RSREG_EN
      test_reg_shift();
`endif
      test_stall();
      test_reset_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/shift_operand_decoder.md
Name: shift_operand_decoder

Overview:
- Decodes the ARM data-processing operand2 field into control for the combinational barrel shifter.
- Drives the shifter's `a`, opcode, shift amount and carry-in. Computes the architectural shifter carry-out itself.
- Register-shifted-register forms need a second register-file read (Rs) over a request/valid handshake, so the block is a small FSM between decode and the shifter/ALU.

Parameters:
- NONE_REQUIRED, n/a, block is fixed 32-bit ARM; no parameters.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept; high only in IDLE
- in_i  input  1  instruction I bit (1 = rotated immediate)
- in_op2  input  12  operand2 field, instr[11:0]
- in_rm_data  input  32  Rm read data, sampled at accept
- in_carry  input  1  current CPSR C
- rs_req  output  1  Rs read request
- rs_addr  output  4  Rs register number (in_op2[11:8] captured)
- rs_valid  input  1  Rs data valid
- rs_data  input  32  Rs read data
- out_valid  output  1  shifter controls valid
- out_ready  input  1  consumer accepts
- sh_a  output  32  shifter data input
- sh_opcode  output  3  shifter op: 0 LSL, 1 LSR, 2 ASR, 3 ROR, 4 RRX
- sh_shift  output  5  shifter amount
- sh_carry_in  output  1  carry fed to the shifter (the C captured at accept)
- carry_out  output  1  architectural shifter carry-out
- illegal  output  1  operand encoding not supported

Behaviour:
- Shifter semantics the decoder must target:
  - LSR with shift 0 yields 0.
  - ASR with shift 0 yields 0.
  - ROR rotates LEFT by shift.
  - RRX = {carry, a[31:1]}.
- FSM states: IDLE, RS_WAIT, OUT.
  - All outputs are registered except in_ready, which equals (state==IDLE).
- Reset (async): state=IDLE; rs_req, rs_addr, out_valid, sh_a, sh_opcode, sh_shift, sh_carry_in, carry_out and illegal all 0.
- Accept: on in_valid & in_ready, capture in_i, in_op2, in_rm_data and in_carry.
- Rotated immediate (in_i=1): next state OUT, latency 1 cycle.
  - rot = in_op2[11:8]; sh_a = zero-extended in_op2[7:0]; opcode ROR; sh_shift = (32 - 2*rot) mod 32.
  - carry_out = in_carry if rot==0, else bit 31 of the rotated immediate.
- Immediate shift (in_i=0, in_op2[4]=0): next state OUT. n = in_op2[11:7], type = in_op2[6:5].
  - LSL: shift n. carry = in_carry if n==0, else rm[32-n].
  - LSR: shift n; n==0 encodes #32 and relies on the shifter's zero result. carry = rm[31] if n==0, else rm[n-1].
  - ASR, n==0: sh_a = {32{rm[31]}}, opcode LSL, shift 0, carry = rm[31].
  - ASR, n!=0: opcode ASR, shift n, carry = rm[n-1].
  - ROR, n==0: opcode RRX, carry = rm[0].
  - ROR, n!=0: shift = 32 - n, carry = rm[n-1].
- Register shift (in_i=0, in_op2[4]=1, in_op2[7]=0):
  - Go to RS_WAIT. rs_req=1 and rs_addr are held until rs_valid; rs_data is sampled on that cycle; next state OUT.
  - n = rs_data[7:0].
  - n==0 (any type): sh_a = rm, LSL, shift 0, carry = in_carry.
  - LSL: 1..31 normal. 32: sh_a=0, carry=rm[0]. >32: sh_a=0, carry=0.
  - LSR: 1..31 normal. 32: opcode LSR, shift 0, carry=rm[31]. >32: sh_a=0, carry=0.
  - ASR: 1..31 normal. >=32: sh_a = {32{rm[31]}}, LSL, shift 0, carry=rm[31].
  - ROR, n[4:0]==0: sh_a=rm, LSL, shift 0, carry=rm[31].
  - ROR, otherwise: shift = 32 - n[4:0], carry = rm[n[4:0]-1].
  - "sh_a=0" cases use opcode LSL, shift 0.
- in_op2[4]=1 with in_op2[7]=1 (multiply space): illegal=1, sh_a=rm, LSL, shift 0, carry=in_carry; straight to OUT.
- OUT: outputs are held stable while out_valid & ~out_ready. On out_ready, return to IDLE with out_valid=0.
- No accept during RS_WAIT or OUT; throughput is at most one operand per 2 cycles.
- rs_valid outside RS_WAIT is ignored.
- Reset during RS_WAIT or OUT aborts the operation; rs_req and out_valid drop immediately.

Optional Feature:
- Macro: SHIFT_DECODE_RSREG_EN.
- Defined: register-shifted-register decode and the Rs handshake are present as above.
- Undefined:
  - RS_WAIT does not exist; rs_req is tied 0 and rs_addr is tied 0.
  - Any in_i=0 with in_op2[4]=1 produces illegal=1, sh_a=rm, LSL, shift 0, carry_out=in_carry, 1-cycle latency.

Test Plan:
- Immediate, in_op2=0x4FF, in_carry=0: sh_a=0xFF, ROR, shift=24, carry_out=1 (rotated value 0xFF000000); out_valid 1 cycle after accept.
- Immediate shift, ASR #0, rm=0x80000001: sh_a=0xFFFFFFFF, LSL, shift 0, carry_out=1.
- Immediate shift, ROR #0, rm=0x00000003, in_carry=1: opcode RRX, sh_carry_in=1, carry_out=1.
- Register shift LSR, rs_data=0x20, rm=0x80000000, rs_valid delayed 3 cycles: rs_req held 3 cycles, then opcode LSR, shift 0, carry_out=1; then rs_data=0x21: sh_a=0, carry_out=0.
- Register shift ROR, rs_data=0x40, rm=0x80000000: LSL, shift 0, carry_out=1. Then ROR, rs_data=4, rm=0x0000000F: shift=28, carry_out=1.
- out_ready low 5 cycles: outputs stable and in_ready=0. Assert reset in RS_WAIT: rs_req=0 and out_valid=0 asynchronously, state IDLE. Without the macro, in_op2=0x010 gives illegal=1.
